// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage access controller.
// States, size codes, timeout default and lane-format helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int TIMEOUT_DEF = 255;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      SZ_W:    return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select plus sign/zero extension.
// Ports: rdata word, size code, is_unsigned, byte offset -> data.
module load_align_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = rdata[{off[1], 4'b0000} +: 16];
    sgn      = 1'b0;
    data     = rdata;
    unique case (1'b1)
      (size == SZ_B): begin
        sgn  = ~is_unsigned & byte_sel[7];
        data = {{24{sgn}}, byte_sel};
      end
      (size == SZ_H): begin
        sgn  = ~is_unsigned & half_sel[15];
        data = {{16{sgn}}, half_sel};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: IDLE/REQ/RESP handshake to DRAM.
// Ports: cpu_clk/cpu_rst, req_* from pipeline, stall/rsp_*/faults out, mem_* to DRAM.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign,
  output logic              timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [3:0]          strb_q, strb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                to_q, to_d;

  logic                legal;
  logic [31:0]         ld_data;

  load_align_ext u_ext (
    .rdata       (mem_rdata),
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (off_q),
    .data        (ld_data)
  );

  always_comb begin
    legal     = req_valid & is_aligned(req_size, req_addr[1:0]);
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    rsp_valid = 1'b0;
    timeout   = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall    = legal;
        misalign = req_valid & ~legal;
        if (legal) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          addr_d  = req_addr[ADDR_W-1:2];
          strb_d  = st_strb(req_size, req_addr[1:0]);
          wdata_d = st_data(req_size, req_wdata);
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        // ack in the last allowed cycle still completes normally
        if (mem_ack) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        timeout   = to_q;
        to_d      = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DRAM bus is quiet outside REQ; strobes only for stores
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q, 2'b00} : '0;
  assign mem_wstrb = mem_we ? strb_q : 4'd0;
  assign mem_wdata = mem_we ? wdata_q : 32'd0;
  assign rsp_rdata = rdata_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of REQ-state cycles to wait for mem_ack before aborting.
REQ-002 Parameter ADDR_W, default 32: width of the address.
REQ-003 The block SHALL have one clock, cpu_clk, and one synchronous, active-high reset, cpu_rst.
REQ-004 cpu_clk  in  1  system clock; all state updates on its rising edge.
REQ-005 cpu_rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  MEM-stage load/store present.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 req_unsigned  in  1  1 = zero-extend the load (ld.bu/ld.hu), 0 = sign-extend.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 stall  out  1  freezes the pipeline.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  32  extended load data.
REQ-015 misalign  out  1  one-cycle alignment-fault pulse.
REQ-016 timeout  out  1  one-cycle abort pulse, coincident with rsp_valid.
REQ-017 mem_req  out  1  DRAM request.
REQ-018 mem_we  out  1  DRAM write enable.
REQ-019 mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0.
REQ-020 mem_wstrb  out  4  byte-lane write strobes.
REQ-021 mem_wdata  out  32  lane-replicated store data.
REQ-022 mem_ack  in  1  DRAM done; mem_rdata is valid in the same cycle.
REQ-023 mem_rdata  in  32  DRAM read word.

Function
REQ-024 The state machine SHALL have the states IDLE, REQ and RESP; the reset state is IDLE.
REQ-025 IDLE, request legal (req_valid=1 and aligned): latch we, size, unsigned, addr[1:0] and the lane-formatted wdata/wstrb, then go to REQ.
REQ-026 Legality: a half-word request needs addr[0]=0, a word request needs addr[1:0]=0, and size=3 is always illegal.
REQ-027 IDLE, request illegal: drive misalign=1 for that cycle only, with stall=0 and mem_req=0; the state stays IDLE and no memory access occurs.
REQ-028 stall SHALL be combinational: stall = (IDLE and legal req_valid) or REQ.
REQ-029 stall SHALL be 0 in RESP.
REQ-030 In REQ, mem_req SHALL be held at 1 with mem_we, mem_addr, mem_wstrb and mem_wdata stable until mem_ack is sampled at 1.
REQ-031 On mem_ack, the block SHALL capture the extended load data into rsp_rdata (0 for stores) and go to RESP.
REQ-032 A cycle counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-033 If the counter reaches TIMEOUT-1 with mem_ack=0, the block SHALL drop mem_req and go to RESP with timeout=1 and rsp_rdata=0.
REQ-034 If mem_ack=1 in the timeout cycle, mem_ack SHALL win and timeout SHALL stay 0.
REQ-035 RESP SHALL last exactly one cycle with rsp_valid=1, then go to IDLE; req_valid SHALL be ignored in RESP.
REQ-036 Latency SHALL be accept cycle N, mem_req from N+1, mem_ack at cycle M, rsp_valid at M+1; the minimum is 3 cycles.
REQ-037 Stores SHALL set strobes/data as: byte gives wstrb=0001<<a[1:0] and wdata={4{b}}; half gives wstrb=0011<<{a[1],0} and wdata={2{h}}; word gives 1111 and wdata unchanged.
REQ-038 Loads SHALL select the byte lane by a[1:0] and the half lane by a[1], then apply a 24/16-bit sign or zero extension per unsigned; words pass through unchanged.
REQ-039 A mem_ack arriving while the state is IDLE or RESP SHALL be ignored.

Reset
REQ-040 When cpu_rst=1 at a rising edge, the state SHALL become IDLE and the counter 0.
REQ-041 Reset SHALL zero every output: stall, rsp_valid, rsp_rdata, misalign, timeout, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata.
REQ-042 A reset during REQ SHALL abandon the access with no rsp_valid; a later mem_ack SHALL be ignored.

Structure
REQ-043 Package mem_ctrl_pkg SHALL hold the state encoding, the size codes (SZ_B/SZ_H/SZ_W) and the TIMEOUT default.
REQ-044 The design SHALL have one combinational sub-module, load_align_ext, covering lane select and sign/zero extension.

Verification
REQ-045 Byte load: ld.b at addr 0x103, mem_rdata=0x80FF_1234, ack after 2 cycles -> rsp_rdata=0xFFFF_FF80, rsp_valid 1 cycle after ack, stall 0 in RESP.
REQ-046 Unsigned half load: ld.hu at 0x102, mem_rdata=0x8001_0000 -> rsp_rdata=0x0000_8001.
REQ-047 Byte store: st.b at 0x101, wdata=0x0000_00AB -> mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x100.
REQ-048 Misaligned: word load at 0x102 -> misalign pulse, stall=0, mem_req never asserted.
REQ-049 Timeout: no ack -> mem_req high for exactly TIMEOUT cycles, then timeout=rsp_valid=1 with rsp_rdata=0; ack in the final cycle -> timeout=0.
REQ-050 Reset mid-REQ: cpu_rst pulse during REQ, then late ack -> all outputs 0, no rsp_valid.
